multicycle_control: RTL

//  Main control FSM of the multicycle MIPS datapath; directly upstream of ula_control.

---
 rtl/multicycle_control.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS datapath: steps each instruction through
// fetch/decode/execute/memory/writeback, stalls on mem_ready, counts retirements.
module multicycle_control #(
  parameter int USE_MEM_READY = 1,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic [1:0]       ula_operation,
  output logic             ula_src_a,
  output logic [1:0]       ula_src_b,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic [1:0]       pc_source,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_count,
  output logic             illegal_op
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    FETCH     = 4'd1,
    DECODE    = 4'd2,
    MEM_ADDR  = 4'd3,
    MEM_READ  = 4'd4,
    MEM_WB    = 4'd5,
    MEM_WRITE = 4'd6,
    EXECUTE   = 4'd7,
    R_WB      = 4'd8,
    BRANCH    = 4'd9,
    JUMP      = 4'd10,
    ADDI_EXEC = 4'd11,
    ADDI_WB   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  state_t state_q, state_d;
  logic   ready, retire, bad_op;
  logic   in_fetch, pc_jump;

  assign ready = (USE_MEM_READY != 0) ? mem_ready : 1'b1;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = IDLE;
    retire  = 1'b0;
    bad_op  = 1'b0;
    case (state_q)
      IDLE:     state_d = FETCH;
      FETCH:    state_d = ready ? DECODE : FETCH;
      DECODE: begin
        case (opcode)
          OP_RTYPE:      state_d = EXECUTE;
          OP_LW, OP_SW:  state_d = MEM_ADDR;
          OP_BEQ:        state_d = BRANCH;
          OP_J:          state_d = JUMP;
          OP_ADDI:       state_d = ADDI_EXEC;
          default: begin
            state_d = FETCH;
            bad_op  = 1'b1;
          end
        endcase
      end
      MEM_ADDR:  state_d = (opcode == OP_SW) ? MEM_WRITE : MEM_READ;
      MEM_READ:  state_d = ready ? MEM_WB : MEM_READ;
      MEM_WB:    begin state_d = FETCH; retire = 1'b1; end
      MEM_WRITE: begin state_d = ready ? FETCH : MEM_WRITE; retire = ready; end
      EXECUTE:   state_d = R_WB;
      R_WB:      begin state_d = FETCH; retire = 1'b1; end
      BRANCH:    begin state_d = FETCH; retire = 1'b1; end
      JUMP:      begin state_d = FETCH; retire = 1'b1; end
      ADDI_EXEC: state_d = ADDI_WB;
      ADDI_WB:   begin state_d = FETCH; retire = 1'b1; end
      default:   state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state, so they line up with state_q as a Moore decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      instr_count   <= '0;
      illegal_op    <= 1'b0;
      ula_operation <= 2'b00;
      ula_src_a     <= 1'b0;
      ula_src_b     <= 2'b00;
      pc_jump       <= 1'b0;
      pc_write_cond <= 1'b0;
      pc_source     <= 2'b00;
      i_or_d        <= 1'b0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      mem_to_reg    <= 1'b0;
      reg_dst       <= 1'b0;
      reg_write     <= 1'b0;
      in_fetch      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (retire) instr_count <= instr_count + 1'b1;
      if (bad_op) illegal_op  <= 1'b1;

      ula_operation <= 2'b00;
      ula_src_a     <= 1'b0;
      ula_src_b     <= 2'b00;
      pc_jump       <= 1'b0;
      pc_write_cond <= 1'b0;
      pc_source     <= 2'b00;
      i_or_d        <= 1'b0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      mem_to_reg    <= 1'b0;
      reg_dst       <= 1'b0;
      reg_write     <= 1'b0;
      in_fetch      <= 1'b0;
      case (state_d)
        FETCH:     begin mem_read <= 1'b1; ula_src_b <= 2'b01; in_fetch <= 1'b1; end
        DECODE:    ula_src_b <= 2'b11;
        MEM_ADDR:  begin ula_src_a <= 1'b1; ula_src_b <= 2'b10; end
        MEM_READ:  begin mem_read <= 1'b1; i_or_d <= 1'b1; end
        MEM_WB:    begin mem_to_reg <= 1'b1; reg_write <= 1'b1; end
        MEM_WRITE: begin mem_write <= 1'b1; i_or_d <= 1'b1; end
        EXECUTE:   begin ula_src_a <= 1'b1; ula_operation <= 2'b10; end
        R_WB:      begin reg_dst <= 1'b1; reg_write <= 1'b1; end
        BRANCH: begin
          ula_src_a     <= 1'b1;
          ula_operation <= 2'b01;
          pc_write_cond <= 1'b1;
          pc_source     <= 2'b01;
        end
        JUMP:      begin pc_jump <= 1'b1; pc_source <= 2'b10; end
        ADDI_EXEC: begin ula_src_a <= 1'b1; ula_src_b <= 2'b10; end
        ADDI_WB:   reg_write <= 1'b1;
        default:   ;
      endcase
    end
  end

  // The fetch strobes follow mem_ready within the cycle so the IR/PC load only on completion.
  assign ir_write = in_fetch & ready;
  assign pc_write = pc_jump | (in_fetch & ready);
  assign state    = state_q;

endmodule
